// File: rtl/counter_pkg.sv
// Shared constants for the parameterised up/down counter: legal parameter
// ranges and the wrap/saturate mode encoding.
package counter_pkg;
  localparam int WIDTH_MIN    = 2;
  localparam int WIDTH_MAX    = 32;
  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 256;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;
endpackage

// File: rtl/prescaler_tick.sv
// Divides enabled cycles by PRESCALE; tick is high in the enabled cycle that
// completes a period. clr restarts the period and suppresses the tick.
module prescaler_tick #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic tick
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] phase_reg, phase_next;

  always_comb begin
    phase_next = phase_reg;
    tick       = 1'b0;
    if (clr) begin
      phase_next = '0;
    end else if (enable) begin
      if (phase_reg == LAST) begin
        tick       = 1'b1;
        phase_next = '0;
      end else begin
        phase_next = phase_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_reg <= '0;
    else       phase_reg <= phase_next;
  end
endmodule

// File: rtl/param_updown_counter.sv
// Modulo/saturating up/down counter with prescaled stepping, synchronous
// clamped load, terminal-count pulse and sticky overflow/underflow flags.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MOD_MAX  = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE = 0,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] data,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [WIDTH-1:0] MAX_VAL = MOD_MAX[WIDTH-1:0];
  localparam mode_e            MODE    = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] count_reg, count_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             step;
  logic             boundary;

  // Load doubles as the prescaler clear, so a load never coincides with a step.
  prescaler_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clr    (load),
    .tick   (step)
  );

  assign boundary = up_down ? (count_reg == MAX_VAL) : (count_reg == '0);

  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    if (load) begin
      count_next = (data > MAX_VAL) ? MAX_VAL : data;
    end else begin
      if (clear_flags) begin
        ovf_next = 1'b0;
        unf_next = 1'b0;
      end
      // A boundary step sets its flag after the clear so that set wins.
      if (step) begin
        if (boundary) begin
          tc_next = 1'b1;
          if (up_down) ovf_next = 1'b1;
          else         unf_next = 1'b1;
          if (MODE == MODE_WRAP) count_next = up_down ? '0 : MAX_VAL;
        end else begin
          count_next = up_down ? count_reg + WIDTH'(1) : count_reg - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign count     = count_reg;
  assign tc        = tc_reg;
  assign overflow  = ovf_reg;
  assign underflow = unf_reg;
endmodule

// File: tb/tb_param_updown_counter.sv
// Drives three counter variants (wrap/P1, saturate/P1, wrap/P3, all MOD_MAX=9)
// with shared directed stimulus; a behavioural model is compared every cycle.
module tb_param_updown_counter;
  localparam int MAXV = 9;
  localparam int PRE_T [3] = '{1, 1, 3};
  localparam int SAT_T [3] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic       up_down = 1'b1;
  logic [3:0] data = 4'd0;
  logic       clear_flags = 1'b0;

  logic [3:0] cnt_o [3];
  logic       tc_o  [3];
  logic       ovf_o [3];
  logic       unf_o [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(0), .PRESCALE(1)) dut_wrap (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .up_down(up_down),
    .data(data), .clear_flags(clear_flags), .count(cnt_o[0]), .tc(tc_o[0]),
    .overflow(ovf_o[0]), .underflow(unf_o[0]));

  param_updown_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1), .PRESCALE(1)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .up_down(up_down),
    .data(data), .clear_flags(clear_flags), .count(cnt_o[1]), .tc(tc_o[1]),
    .overflow(ovf_o[1]), .underflow(unf_o[1]));

  param_updown_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(0), .PRESCALE(3)) dut_pre (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .up_down(up_down),
    .data(data), .clear_flags(clear_flags), .count(cnt_o[2]), .tc(tc_o[2]),
    .overflow(ovf_o[2]), .underflow(unf_o[2]));

  // Model: pre counts enabled cycles modulo PRESCALE; a step is the enabled
  // cycle that brings it back to zero.
  typedef struct {
    int cnt;
    int pre;
    bit tc;
    bit ovf;
    bit unf;
  } mstate_t;

  mstate_t m [3];

  function automatic mstate_t model_next(mstate_t s, int i, bit en, bit ld, bit ud,
                                         bit clr, int d);
    mstate_t n = s;
    bit bnd;
    n.tc = 1'b0;
    if (ld) begin
      n.cnt = (d > MAXV) ? MAXV : d;
      n.pre = 0;
      return n;
    end
    if (clr) begin
      n.ovf = 1'b0;
      n.unf = 1'b0;
    end
    if (en) begin
      n.pre = (s.pre + 1) % PRE_T[i];
      if (n.pre == 0) begin
        bnd = ud ? (s.cnt == MAXV) : (s.cnt == 0);
        if (ud) n.cnt = (SAT_T[i] != 0) ? ((s.cnt + 1 > MAXV) ? MAXV : s.cnt + 1)
                                        : (s.cnt + 1) % (MAXV + 1);
        else    n.cnt = (SAT_T[i] != 0) ? ((s.cnt - 1 < 0) ? 0 : s.cnt - 1)
                                        : (s.cnt + MAXV) % (MAXV + 1);
        if (bnd) begin
          n.tc = 1'b1;
          if (ud) n.ovf = 1'b1;
          else    n.unf = 1'b1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) m[i] <= '{0, 0, 1'b0, 1'b0, 1'b0};
    end else begin
      for (int i = 0; i < 3; i++)
        m[i] <= model_next(m[i], i, enable, load, up_down, clear_flags, int'(data));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_cnt%0d", i), int'(cnt_o[i]), m[i].cnt);
      check($sformatf("model_tc%0d", i),  int'(tc_o[i]),  int'(m[i].tc));
      check($sformatf("model_ovf%0d", i), int'(ovf_o[i]), int'(m[i].ovf));
      check($sformatf("model_unf%0d", i), int'(unf_o[i]), int'(m[i].unf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc=%0d rst=%0b en=%0b ld=%0b ud=%0b d=%0d clr=%0b | cnt=%0d/%0d/%0d tc=%0b%0b%0b ovf=%0b%0b%0b unf=%0b%0b%0b",
             cyc, reset, enable, load, up_down, data, clear_flags,
             cnt_o[0], cnt_o[1], cnt_o[2], tc_o[0], tc_o[1], tc_o[2],
             ovf_o[0], ovf_o[1], ovf_o[2], unf_o[0], unf_o[1], unf_o[2]);
  endtask

  initial begin
    repeat (2) tick();
    check("reset_cnt0", int'(cnt_o[0]), 0);
    reset = 1'b0;

    // Wrap count 1..9,0 with tc and overflow on the 9->0 step.
    enable = 1'b1; up_down = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("up_cnt0", int'(cnt_o[0]), k % 10);
      check("up_tc0", int'(tc_o[0]), (k == 10) ? 1 : 0);
    end
    check("up_ovf0", int'(ovf_o[0]), 1);
    check("sat_hold_cnt1", int'(cnt_o[1]), 9);
    check("pre3_cnt2", int'(cnt_o[2]), 3);
    enable = 1'b0;
    tick();
    check("tc_one_cycle0", int'(tc_o[0]), 0);

    // Down step at 0 wraps to 9, underflow set, then cleared.
    up_down = 1'b0; enable = 1'b1;
    tick();
    enable = 1'b0;
    check("down_wrap_cnt0", int'(cnt_o[0]), 9);
    check("down_unf0", int'(unf_o[0]), 1);
    check("down_tc0", int'(tc_o[0]), 1);
    tick();
    check("down_tc_end0", int'(tc_o[0]), 0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("clear_unf0", int'(unf_o[0]), 0);
    check("clear_ovf0", int'(ovf_o[0]), 0);

    // Clamped load, then saturating up steps.
    load = 1'b1; data = 4'd12;
    tick();
    load = 1'b0;
    check("load_clamp_cnt1", int'(cnt_o[1]), 9);
    check("load_clamp_cnt0", int'(cnt_o[0]), 9);
    up_down = 1'b1; enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("sat_cnt1", int'(cnt_o[1]), 9);
      check("sat_tc1", int'(tc_o[1]), 1);
    end
    check("sat_ovf1", int'(ovf_o[1]), 1);
    check("wrap_after_load_cnt0", int'(cnt_o[0]), 1);
    enable = 1'b0;
    tick();
    check("sat_tc_end1", int'(tc_o[1]), 0);

    // Prescale 3 with a two-cycle enable gap mid-period.
    load = 1'b1; data = 4'd0;
    tick();
    load = 1'b0; enable = 1'b1;
    tick(); tick();
    check("pre_no_step_cnt2", int'(cnt_o[2]), 0);
    tick();
    check("pre_step_cnt2", int'(cnt_o[2]), 1);
    tick();
    enable = 1'b0;
    tick(); tick();
    enable = 1'b1;
    tick();
    check("pre_delayed_cnt2", int'(cnt_o[2]), 1);
    tick();
    check("pre_after_gap_cnt2", int'(cnt_o[2]), 2);
    enable = 1'b0;

    // Boundary up step coinciding with clear_flags: set wins.
    load = 1'b1; data = 4'd9;
    tick();
    load = 1'b0; clear_flags = 1'b1;
    tick();
    check("pre_clear_ovf0", int'(ovf_o[0]), 0);
    enable = 1'b1; up_down = 1'b1;
    tick();
    enable = 1'b0; clear_flags = 1'b0;
    check("set_wins_ovf0", int'(ovf_o[0]), 1);
    check("set_wins_ovf1", int'(ovf_o[1]), 1);

    // Asynchronous reset between edges at count 7.
    load = 1'b1; data = 4'd7;
    tick();
    load = 1'b0;
    check("pre_reset_cnt0", int'(cnt_o[0]), 7);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_cnt0", int'(cnt_o[0]), 0);
    check("async_rst_ovf0", int'(ovf_o[0]), 0);
    check("async_rst_ovf1", int'(ovf_o[1]), 0);
    check("async_rst_tc0", int'(tc_o[0]), 0);
    tick();
    reset = 1'b0;

    // First step after reset comes PRESCALE enabled cycles later.
    enable = 1'b1; up_down = 1'b1;
    tick(); tick();
    check("post_rst_wait_cnt2", int'(cnt_o[2]), 0);
    check("post_rst_cnt0", int'(cnt_o[0]), 2);
    tick();
    check("post_rst_step_cnt2", int'(cnt_o[2]), 1);
    enable = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
